// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus a stability FSM: a new level is accepted only after
// STABLE_CYCLES equal samples. Optional reject counter via DEBOUNCE_GLITCH_CNT_EN.
module input_debouncer #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = $clog2(STABLE_CYCLES),
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a,
  output logic                level,
  output logic                rise,
  output logic                fall
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  typedef enum logic [1:0] {ST_LO, WAIT_HI, ST_HI, WAIT_LO} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             s1;
  logic             a_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      a_s <= 1'b0;
    end else begin
      s1  <= a;
      a_s <= s1;
    end
  end

  // Count starts at 1 on WAIT entry, so the compare fires on the STABLE_CYCLES-th equal sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ST_LO: begin
          if (a_s) begin
            state <= WAIT_HI;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_HI: begin
          if (!a_s) begin
            state <= ST_LO;
          end else if (cnt == CNT_LAST) begin
            state <= ST_HI;
            level <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HI: begin
          if (!a_s) begin
            state <= WAIT_LO;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_LO: begin
          if (a_s) begin
            state <= ST_HI;
          end else if (cnt == CNT_LAST) begin
            state <= ST_LO;
            level <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_LO;
      endcase
    end
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic abort;
  assign abort = (state == WAIT_HI && !a_s) || (state == WAIT_LO && a_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      glitch_cnt <= '0;
    else if (abort && glitch_cnt != '1)
      glitch_cnt <= glitch_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Randomised and directed bench for input_debouncer against a run-length model
// of the accepted-level rule.
module tb_input_debouncer;
  localparam int S  = 4;
  localparam int GW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic a;
  logic level, rise, fall;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [GW-1:0] glitch_cnt;
`endif

  input_debouncer #(.STABLE_CYCLES(S), .GLITCH_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .a(a),
    .level(level), .rise(rise), .fall(fall)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_cnt(glitch_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model: the FSM sees a twice-delayed copy of a; level flips once the
  // current run of identical samples opposite to level reaches S.
  logic m_s1 = 0, m_as = 0, m_prev = 0, m_level = 0, m_rise = 0, m_fall = 0;
  int   m_run = 0, m_glitch = 0;

  always @(posedge clk or negedge rst_n) begin
    logic v;
    if (!rst_n) begin
      m_s1 = 0; m_as = 0; m_prev = 0; m_level = 0; m_rise = 0; m_fall = 0;
      m_run = 0; m_glitch = 0;
    end else begin
      v = m_as;
      m_as = m_s1;
      m_s1 = a;
      if (v == m_prev) m_run = m_run + 1;
      else m_run = 1;
      m_rise = 0;
      m_fall = 0;
      if (v != m_level && m_run >= S) begin
        m_level = v;
        m_rise  = v;
        m_fall  = !v;
      end else if (v == m_level && m_prev != m_level) begin
        if (m_glitch < (1 << GW) - 1) m_glitch = m_glitch + 1;
      end
      m_prev = v;
    end
  end

  int total = 0, bad = 0;
  int nr, nf;
  logic prev_p = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: compare DUT with the model at the negedge, then drive the next input.
  task automatic tick(input logic v);
    @(negedge clk);
    chk("level", level, m_level);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("rise_and_fall", rise & fall, 0);
    chk("back_to_back", prev_p & (rise | fall), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("glitch_cnt", glitch_cnt, m_glitch);
`endif
    prev_p = rise | fall;
    nr += rise;
    nf += fall;
    a = v;
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) tick(v);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_rise"}, rise, 0);
    chk({tag, "_fall"}, fall, 0);
  endtask

  initial begin
    int g0;
    logic [3:0] pat [10] = '{1,0,1,1,0,1,1,1,1,1};
    rst_n = 1'b1;
    a = 1'b0;
    nr = 0; nf = 0; g0 = 0;
    #1 rst_n = 1'b0;

    // Reset held with a toggling: outputs must stay 0.
    for (int i = 0; i < 8; i++) tick(i[0]);
    check_zero("reset");
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("reset_glitch", glitch_cnt, 0);
`endif
    tick(1'b0);
    rst_n = 1'b1;
    hold(1'b0, 6);
    check_zero("idle");

    // Three-cycle excursion is rejected.
    nr = 0; nf = 0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    g0 = int'(glitch_cnt);
`endif
    hold(1'b1, 3);
    hold(1'b0, 10);
    chk("glitch_no_rise", nr, 0);
    chk("glitch_level", level, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("glitch_cnt_one", int'(glitch_cnt) - g0, 1);
`endif

    // Clean rise: edge k samples the new value, rise visible after edge k+5.
    nr = 0; nf = 0;
    tick(1'b1);
    hold(1'b1, 5);
    chk("rise_early", rise, 0);
    chk("level_early", level, 0);
    hold(1'b1, 1);
    chk("rise_lat", rise, 1);
    chk("level_lat", level, 1);
    hold(1'b1, 1);
    chk("rise_one_cycle", rise, 0);
    chk("level_held", level, 1);
    hold(1'b1, 3);
    chk("clean_rise_count", nr, 1);

    // Clean fall.
    nr = 0; nf = 0;
    hold(1'b0, 6);
    hold(1'b0, 2);
    chk("fall_count", nf, 1);
    chk("fall_no_rise", nr, 0);
    chk("fall_level", level, 0);

    // Bouncy press.
    nr = 0; nf = 0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    g0 = int'(glitch_cnt);
`endif
    for (int i = 0; i < 10; i++) tick(pat[i][0]);
    hold(1'b1, 4);
    chk("bouncy_rise_count", nr, 1);
    chk("bouncy_level", level, 1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    chk("bouncy_glitch", int'(glitch_cnt) - g0, 2);
`endif

    // Reset while level is high drops outputs without a clock edge.
    #2 rst_n = 1'b0;
    #1 check_zero("async_hi");
    tick(1'b0);
    rst_n = 1'b1;
    hold(1'b0, 6);

    // Reset two cycles into a high run, then a full count after release.
    nr = 0; nf = 0;
    hold(1'b1, 4);
    #2 rst_n = 1'b0;
    #1 check_zero("async_wait");
    hold(1'b1, 3);
    rst_n = 1'b1;
    hold(1'b1, 5);
    chk("rel_rise_early", rise, 0);
    hold(1'b1, 1);
    chk("rel_rise_lat", rise, 1);
    chk("rel_level", level, 1);

    // Random segments of varying length.
    for (int s = 0; s < 300; s++) begin
      logic v;
      v = logic'($urandom_range(0, 1));
      hold(v, $urandom_range(1, 8));
    end
    hold(a, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
